// File: rtl/pipe_stall_if.sv
// Stall/flush controller handshake bundle: hazard requests from the pipeline stages
// and the hold/bubble/flush controls returned to them.
interface pipe_stall_if #(
  parameter int CNT_W  = 4,
  parameter int PERF_W = 32
);
  logic              id_load_use;
  logic              ex_multi_start;
  logic [CNT_W-1:0]  ex_multi_cycles;
  logic              mem_wait;
  logic              id_branch_taken;
  logic [4:0]        stall;
  logic              bubble_idex;
  logic              bubble_exmem;
  logic              bubble_memwb;
  logic              flush_ifid;
  logic              ex_busy;
  logic              ex_done;
  logic [PERF_W-1:0] stall_cycles;

  // Pipeline side: raises requests, consumes controls.
  modport master (
    output id_load_use, ex_multi_start, ex_multi_cycles, mem_wait, id_branch_taken,
    input  stall, bubble_idex, bubble_exmem, bubble_memwb, flush_ifid,
    input  ex_busy, ex_done, stall_cycles
  );

  // Controller side.
  modport slave (
    input  id_load_use, ex_multi_start, ex_multi_cycles, mem_wait, id_branch_taken,
    output stall, bubble_idex, bubble_exmem, bubble_memwb, flush_ifid,
    output ex_busy, ex_done, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller and EX multi-cycle sequencer for the 5-stage pipeline.
// Optional stall-cycle counter enabled by macro PIPE_STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int CNT_W  = 4,
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_stall_if.slave  bus
);
  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_BUSY  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] n_s;
  logic             ex_stall_s;
  logic             ex_done_s;
  logic [4:0]       stall_s;
  logic             bubble_idex_s;
  logic             bubble_exmem_s;
  logic             bubble_memwb_s;

  // Effective op length: a zero length still occupies EX for one cycle.
  always_comb begin
    if (bus.ex_multi_cycles == CNT_ZERO) begin
      n_s = CNT_ONE;
    end else begin
      n_s = bus.ex_multi_cycles;
    end
  end

  // Sequencer next state; count holds the remaining cycles after the next one.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    ex_stall_s  = 1'b0;
    ex_done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ex_multi_start && !bus.mem_wait) begin
          if (n_s == CNT_ONE) begin
            ex_done_s = 1'b1;
          end else begin
            state_nxt_s = ST_BUSY;
            count_nxt_s = n_s - CNT_TWO;
            ex_stall_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.mem_wait) begin
          ex_stall_s = 1'b1;
        end else if (count_r == CNT_ZERO) begin
          ex_done_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          count_nxt_s = count_r - CNT_ONE;
          ex_stall_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      count_r <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Hold/bubble priority: a stalled later stage freezes everything upstream of it.
  always_comb begin
    stall_s        = 5'b00000;
    bubble_idex_s  = 1'b0;
    bubble_exmem_s = 1'b0;
    bubble_memwb_s = 1'b0;
    if (rst) begin
      stall_s = 5'b00000;
    end else if (bus.mem_wait) begin
      stall_s        = 5'b01111;
      bubble_memwb_s = 1'b1;
    end else if (ex_stall_s) begin
      stall_s        = 5'b00111;
      bubble_exmem_s = 1'b1;
    end else if (bus.id_load_use) begin
      stall_s       = 5'b00011;
      bubble_idex_s = 1'b1;
    end else begin
      stall_s = 5'b00000;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.bubble_idex  = bubble_idex_s;
  assign bus.bubble_exmem = bubble_exmem_s;
  assign bus.bubble_memwb = bubble_memwb_s;
  // A held branch stays in ID and flushes on its first unstalled cycle.
  assign bus.flush_ifid   = !rst && bus.id_branch_taken && !stall_s[1];
  assign bus.ex_busy      = !rst && (state_r == ST_BUSY);
  assign bus.ex_done      = !rst && ex_done_s;

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] stall_cycles_r;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r <= {PERF_W{1'b0}};
    end else if (stall_s[0] && (stall_cycles_r != {PERF_W{1'b1}})) begin
      stall_cycles_r <= stall_cycles_r + PERF_W'(1);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

  assign bus.stall_cycles = rst ? {PERF_W{1'b0}} : stall_cycles_r;
`else
  assign bus.stall_cycles = {PERF_W{1'b0}};
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage toy CPU pipeline (IF, ID, EX, MEM, WB).
- Collects hazard and wait requests from the stages:
  - load-use hazard from ID;
  - multi-cycle ALU op from EX;
  - memory wait from MEM;
  - taken branch from ID.
- Drives per-register hold, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Owns the EX multi-cycle sequencer (FSM plus countdown), so the ID/EX register and the ALUs never time multi-cycle ops themselves.

Parameters:
- CNT_W, default 4: width of the multi-cycle length input and of the internal countdown.
- PERF_W, default 32: width of the stall-cycle counter. Used only with the optional feature.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- id_load_use, in, 1: ID instruction needs a load result still in EX.
- ex_multi_start, in, 1: EX holds a multi-cycle op. Stays asserted while ID/EX is held.
- ex_multi_cycles, in, CNT_W: total EX cycles for the op. 0 is treated as 1.
- mem_wait, in, 1: MEM access not complete this cycle.
- id_branch_taken, in, 1: branch resolved taken in ID.
- stall, out, 5: hold enables. bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- bubble_idex, out, 1: load NOP into ID/EX (alusel ALU_NOP, memop MEM_OP_NOP, writeEnable DISABLE).
- bubble_exmem, out, 1: load NOP into EX/MEM.
- bubble_memwb, out, 1: load NOP into MEM/WB.
- flush_ifid, out, 1: replace the IF/ID instruction with NOP.
- ex_busy, out, 1: sequencer in BUSY.
- ex_done, out, 1: one-cycle pulse on the final EX cycle of a multi-cycle op.
- stall_cycles, out, PERF_W: optional; stall-cycle counter.

Behaviour:
- Outputs are combinational from the registered state, count and current inputs. The only registers are state, count and (optionally) stall_cycles.
- Reset values (forced while rst=1):
  - state=IDLE, count=0, stall_cycles=0;
  - stall=5'b00000;
  - all bubble and flush outputs 0;
  - ex_busy=0, ex_done=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - Start is accepted when ex_multi_start=1 and mem_wait=0.
  - Let N = max(ex_multi_cycles, 1).
  - N=1: stay IDLE, ex_done=1 this cycle, no EX stall.
  - N>1: go to BUSY with count=N-2, and stall EX this cycle.
- BUSY:
  - Each cycle with mem_wait=0: if count==0, assert ex_done and go to IDLE; otherwise count decrements.
  - mem_wait=1 freezes count and state, and ex_done is suppressed.
  - ex_multi_start is ignored while in BUSY.
- ex_stall is 1 when:
  - state=BUSY and not the count==0 exit cycle, or
  - state=IDLE on a start with N>1.
  - Total EX occupancy is therefore exactly N cycles when mem_wait stays 0.
- Stall priority, highest first, exactly one row applies:
  1. mem_wait=1: stall=5'b01111, bubble_memwb=1.
  2. ex_stall=1: stall=5'b00111, bubble_exmem=1.
  3. id_load_use=1: stall=5'b00011, bubble_idex=1.
  4. Otherwise: stall=0 and no bubbles.
- Branches:
  - flush_ifid = id_branch_taken & ~stall[1].
  - While ID is held, the branch stays in ID and flushes on its first unstalled cycle. No pending register is kept.
- Simultaneous events:
  - load_use together with a branch: the stall wins and flush_ifid=0.
  - mem_wait in the same cycle as a start: the start is not accepted, and is retried when mem_wait drops.
- rst mid-op: BUSY is abandoned immediately and no ex_done is issued.
- count cannot wrap: it is loaded only from N-2 with N≥2, and is only decremented when nonzero.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined:
  - stall_cycles increments by 1 in every non-reset cycle where stall[0]=1.
  - It saturates at all-ones and never wraps.
  - It is cleared only by rst.
- Undefined: the stall_cycles port stays present, is tied to 0, and no counter register is built.

Test Plan:
- Reset: hold rst=1 3 cycles with all inputs 1 → all outputs 0. Release rst with inputs 0 → stall=0, state IDLE.
- Multi-cycle op: ex_multi_start=1, cycles=4, mem_wait=0 →
  - stall=00111 and bubble_exmem=1 for exactly 3 cycles;
  - ex_done pulses in the 4th cycle, with stall=0 in that cycle.
- Single/zero cycle: cycles=0 and cycles=1 → ex_done=1 in the same cycle, ex_busy=0, stall=0.
- Freeze: during BUSY of a cycles=5 op, assert mem_wait for 2 cycles →
  - stall=01111 and bubble_memwb=1 for those 2 cycles;
  - count holds;
  - ex_done arrives 2 cycles later than without the wait (7th cycle).
- Priority: id_load_use=1 together with id_branch_taken=1 → stall=00011, bubble_idex=1, flush_ifid=0. Next cycle with load_use=0 → flush_ifid=1, stall=0.
- Perf (PIPE_STALL_PERF_EN defined):
  - 10 stall cycles → stall_cycles=10.
  - Preload near max (PERF_W=4, 20 stall cycles) → saturates at 15.
  - Macro undefined → stall_cycles=0 throughout.
